lab1_response_checker: RTL

Hardware self-checking harness for the Lab1 4-input, 1-output function.
- Sequences all 16 {A,B,C,D} input vectors into NUM_IMPL parallel implementations (gate-level, dataflow, UDP).
- Waits a settle interval per vector, then samples every implementation's F output and compares it against an expected truth table.
- Accumulates sticky per-implementation failure flags, a mismatch count and the first failing vector. This is the response-collecting end of the Lab1 stimulus interface, usable on-board with no simulator.

---
 rtl/lab1_pkg.sv | 24 ++
 rtl/lab1_vec_compare.sv | 19 +
 rtl/lab1_response_checker.sv | 115 +++++++++++
 3 files changed

// File: rtl/lab1_pkg.sv
// Shared types and constants for the Lab1 response checker.
package lab1_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of the applied {A,B,C,D} vector.
    localparam int VEC_W = 4;

    // Last vector of the sweep.
    localparam logic [VEC_W-1:0] VEC_LAST = 4'hF;

    // Settle counter width; enough for SETTLE_CYCLES up to 15.
    localparam int CNT_W = 4;

    // Expected Lab1 response: F = A ^ B ^ C ^ D (bit i = F for vector i).
    localparam logic [15:0] LAB1_TT = 16'h6996;

endpackage

// File: rtl/lab1_vec_compare.sv
// Compares every implementation's F against the expected truth-table bit
// for the currently applied vector.
module lab1_vec_compare
    import lab1_pkg::*;
#(
    parameter int NUM_IMPL = 3
) (
    input  logic [NUM_IMPL-1:0] f_in,
    input  logic [15:0]         expected,
    input  logic [VEC_W-1:0]    vec,
    output logic [NUM_IMPL-1:0] mm,
    output logic                any_mm
);

    // A set bit marks an implementation disagreeing with the truth table.
    assign mm     = f_in ^ {NUM_IMPL{expected[vec]}};
    assign any_mm = |mm;

endmodule

// File: rtl/lab1_response_checker.sv
// Sweeps all 16 Lab1 input vectors, samples NUM_IMPL implementation
// outputs after a settle interval and accumulates sticky failure results.
module lab1_response_checker
    import lab1_pkg::*;
#(
    parameter int          NUM_IMPL      = 3,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = LAB1_TT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [VEC_W-1:0]    vec_out,
    input  logic [NUM_IMPL-1:0] f_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [NUM_IMPL-1:0] fail_mask,
    output logic [4:0]          mismatch_count,
    output logic [VEC_W-1:0]    first_fail_vec,
    output logic                first_fail_valid
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_q;
    logic [VEC_W-1:0]    vec_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pass_q;
    logic [NUM_IMPL-1:0] fail_mask_q;
    logic [4:0]          mm_cnt_q;
    logic [4:0]          mm_cnt_d;
    logic [VEC_W-1:0]    first_vec_q;
    logic                first_valid_q;

    logic [NUM_IMPL-1:0] mm;
    logic                any_mm;

    lab1_vec_compare #(
        .NUM_IMPL (NUM_IMPL)
    ) u_cmp (
        .f_in     (f_in),
        .expected (EXPECTED),
        .vec      (vec_q),
        .mm       (mm),
        .any_mm   (any_mm)
    );

    // Mismatch count including the vector being sampled now; at most 16, so no wrap.
    assign mm_cnt_d = mm_cnt_q + {4'd0, any_mm};

    // Sweep FSM with registered results; reset is synchronous and beats start.
    always_ff @(posedge clk) begin
        // NOTE: all state updates are non-blocking so every register sees
        // the pre-edge values of the others, as real flops do.
        if (rst) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            cnt_q         <= '0;
            pass_q        <= 1'b0;
            fail_mask_q   <= '0;
            mm_cnt_q      <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= SETTLE;
                        vec_q         <= '0;
                        cnt_q         <= '0;
                        pass_q        <= 1'b0;
                        fail_mask_q   <= '0;
                        mm_cnt_q      <= '0;
                        first_vec_q   <= '0;
                        first_valid_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    fail_mask_q <= fail_mask_q | mm;
                    mm_cnt_q    <= mm_cnt_d;
                    if (any_mm && !first_valid_q) begin
                        first_vec_q   <= vec_q;
                        first_valid_q <= 1'b1;
                    end
                    if (vec_q == VEC_LAST) begin
                        state_q <= DONE;
                        pass_q  <= (mm_cnt_d == 5'd0);
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_out          = vec_q;
    assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;
    assign fail_mask        = fail_mask_q;
    assign mismatch_count   = mm_cnt_q;
    assign first_fail_vec   = first_vec_q;
    assign first_fail_valid = first_valid_q;

endmodule
